decode_unit: RTL

//   Consumer end of the fetch interface. Registers each 9-bit instruction_val from fetch_unit,

---
 rtl/decode_unit_pkg.sv | 32 +++
 rtl/decode_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/decode_unit_pkg.sv
// Shared ISA definitions for the decode unit: opcodes, field ranges, state encodings.
package decode_unit_pkg;

  localparam int ISA_INSTR_W = 9;
  localparam int ISA_ADDR_W  = 8;

  // Instruction field bit ranges
  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;
  localparam int TGT_MSB = 5;

  // Opcodes; 3'b000..3'b100 are ALU operations
  localparam logic [2:0] OP_BR   = 3'b111;
  localparam logic [2:0] OP_BRZ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Extract the 6-bit absolute branch target from an instruction
  function automatic logic [TGT_MSB:0] branch_target(input logic [ISA_INSTR_W-1:0] instr);
    return instr[TGT_MSB:0];
  endfunction

endpackage

// File: rtl/decode_unit.sv
// Decode stage: registers each fetched instruction, splits op/rd/rs for execute,
// resolves BR/BRZ back to fetch and squashes wrong-path instructions.
// Optional feature macro: DECODE_STATS_EN adds a saturating taken-branch counter.
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter int INSTR_W      = 9,
  parameter int ADDR_W       = 8,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction_val,
  input  logic               zero_flag,
  output logic [2:0]         op,
  output logic [2:0]         rd,
  output logic [2:0]         rs,
  output logic               dec_valid,
  output logic               branch_ctrl,
  output logic [ADDR_W-1:0]  branch_val,
`ifdef DECODE_STATS_EN
  output logic [15:0]        taken_branch_count,
`endif
  output logic               halted
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       op_next, rd_next, rs_next;
  logic             dec_valid_next, branch_ctrl_next, halted_next;
  logic [ADDR_W-1:0] branch_val_next;
  logic [2:0]       instr_op;

  assign instr_op = instruction_val[OP_MSB:OP_LSB];

  // Next-state and next-output decode; instruction bits are only read in RUN
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    op_next          = op;
    rd_next          = rd;
    rs_next          = rs;
    dec_valid_next   = 1'b0;
    branch_ctrl_next = 1'b0;
    branch_val_next  = branch_val;
    halted_next      = halted;
    case (state)
      ST_RUN: begin
        case (instr_op)
          OP_BR: begin
            branch_ctrl_next = 1'b1;
            branch_val_next  = ADDR_W'(branch_target(instruction_val));
            cnt_next         = CNT_W'(FLUSH_CYCLES);
            state_next       = ST_FLUSH;
          end
          OP_BRZ: begin
            if (zero_flag) begin
              branch_ctrl_next = 1'b1;
              branch_val_next  = ADDR_W'(branch_target(instruction_val));
              cnt_next         = CNT_W'(FLUSH_CYCLES);
              state_next       = ST_FLUSH;
            end else begin
              state_next = ST_RUN;
            end
          end
          OP_HALT: begin
            halted_next = 1'b1;
            state_next  = ST_HALT;
          end
          default: begin
            dec_valid_next = 1'b1;
            op_next        = instr_op;
            rd_next        = instruction_val[RD_MSB:RD_LSB];
            rs_next        = instruction_val[RS_MSB:RS_LSB];
          end
        endcase
      end
      ST_FLUSH: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_FLUSH;
        end
      end
      ST_HALT: begin
        halted_next = 1'b1;
        state_next  = ST_HALT;
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // State, squash counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      op          <= 3'd0;
      rd          <= 3'd0;
      rs          <= 3'd0;
      dec_valid   <= 1'b0;
      branch_ctrl <= 1'b0;
      branch_val  <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      op          <= op_next;
      rd          <= rd_next;
      rs          <= rs_next;
      dec_valid   <= dec_valid_next;
      branch_ctrl <= branch_ctrl_next;
      branch_val  <= branch_val_next;
      halted      <= halted_next;
    end
  end

`ifdef DECODE_STATS_EN
  // Saturating count of taken branches, stepping together with the branch_ctrl pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      taken_branch_count <= 16'd0;
    end else if (branch_ctrl_next && (taken_branch_count != 16'hFFFF)) begin
      taken_branch_count <= taken_branch_count + 16'd1;
    end else begin
      taken_branch_count <= taken_branch_count;
    end
  end
`endif

endmodule
